sync_debounce_bank: RTL and testbench
=====================================

Name: sync_debounce_bank

Overview:
Parametrised multi-channel input conditioner for asynchronous push-buttons and switches feeding the PWM control logic.
- Each channel passes through a configurable-depth synchroniser chain.
- A stable-count debounce filter follows the chain.
- The block outputs a clean level per channel plus single-cycle rise/fall strobes, replacing fixed-depth cascades.
- Optional tick input lets the debounce window be counted in prescaled time, e.g. 1 kHz, instead of raw clocks.

Parameters:
- N_CH, 4: number of independent input channels (>=1).
- SYNC_STAGES, 3: flip-flop stages in each synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 8: consecutive qualifying tick samples needed to accept a new level (>=1).
- CNT_W, 4: debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
- INIT_LEVEL, 0: reset value of every synchroniser flop and of level (1-bit, applies to all channels).

Ports:
- clk, input, 1: system clock; all flops on rising edge.
- rst, input, 1: synchronous, active-high reset.
- tick, input, 1: debounce count enable strobe; tie to 1 to count every clk.
- din, input, N_CH: raw asynchronous inputs, bit i = channel i.
- level, output, N_CH: debounced, synchronised level per channel.
- rise, output, N_CH: one-clk pulse when level[i] goes 0->1.
- fall, output, N_CH: one-clk pulse when level[i] goes 1->0.

Behaviour:
- Reset: rst sampled high at a clk edge sets, in every channel:
  - all synchroniser flops = INIT_LEVEL
  - level = INIT_LEVEL
  - counter = 0
  - rise = fall = 0
- Reset overrides everything. Reset mid-count discards partial progress; no strobe is issued.
- Synchroniser:
  - sync[i] = last stage of an SYNC_STAGES-deep shift chain clocked every clk, independent of tick.
  - din change is visible on sync after SYNC_STAGES edges.
- Debounce, per channel, evaluated at each clk edge when rst=0:
  - sync == level: counter <= 0, regardless of tick. Any bounce back restarts the window.
  - sync != level and tick=0: counter holds.
  - sync != level, tick=1, counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != level, tick=1, counter == DEBOUNCE_CYCLES-1: level <= sync, counter <= 0, and the matching strobe is asserted for exactly this one cycle.
- Strobes:
  - rise/fall are registered and high in the same cycle the new level first appears.
  - rise[i] and fall[i] are never high together.
  - Strobes deassert the next cycle unconditionally.
- Latency with tick=1: din step to level change = SYNC_STAGES + DEBOUNCE_CYCLES clk edges (defaults: 11).
- DEBOUNCE_CYCLES=1: level follows sync on the first qualifying tick.
- Channels are fully independent; simultaneous events on several channels are all processed in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- The synchroniser flops must carry the vendor ASYNC_REG / shreg-extract-off attribute.

Decomposition:
- Shared package pwm_pkg holds:
  - default constants (SYNC_STAGES_DEF, DEBOUNCE_CYCLES_DEF)
  - a clog2 helper function for deriving CNT_W
- One sub-module, debounce_channel:
  - contains the single-channel synchroniser, counter and strobe logic
  - instantiated N_CH times via a generate loop in sync_debounce_bank
- Elaboration-time checks reject SYNC_STAGES<2, DEBOUNCE_CYCLES<1 and CNT_W too small.

Test Plan:
- Reset: hold rst 2 cycles with din=4'hF, defaults -> level=0, rise=fall=0 during and after rst. level stays 0 until 11 edges after rst release, then level=4'hF with rise=4'hF for one cycle.
- Clean step: tick=1, din[0] 0->1 at cycle 0 -> level[0]=1 and rise[0]=1 after edge 11; rise[0]=0 at edge 12. Other bits unchanged.
- Bounce: din[1] toggles 1,0,1,0 every 3 clks, then holds 1 -> no level change during the bounce; level[1] rises exactly 11 edges after the final 0->1.
- Tick gating: tick high 1 clk in 4, din[2] held 1 -> level[2] rises after 3 + 8 ticks (~35 clks). A one-clk glitch back to 0 mid-window restarts the count.
- Simultaneous: din 4'b0101 -> 4'b1010 in one cycle -> after 11 edges, rise=4'b1010 and fall=4'b0101 in the same cycle. level=4'b1010.
- Reset mid-count: din[3]=1, assert rst at edge 7 -> level[3] stays 0, no strobe. After release, a full 11-edge latency elapses before rise[3].

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared defaults and helpers for the PWM input conditioning path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int SYNC_STAGES_DEF     = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 8;

  // Bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : Single-channel synchroniser, stable-count debouncer and strobes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import pwm_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = 4,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_STAGES-1:0] r_sync;

  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;
  logic             w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Any sample matching the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= INIT_LEVEL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (tick) begin
        if (r_cnt == c_LAST) begin
          r_level <= w_sync;
          r_cnt   <= '0;
          r_rise  <= w_sync;
          r_fall  <= ~w_sync;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/sync_debounce_bank.sv
// ============================================================================
// Module      : sync_debounce_bank
// Description : N-channel synchronise + debounce bank with rise/fall strobes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce_bank
  import pwm_pkg::*;
#(
  parameter int   N_CH            = 4,
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = 4,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  if (N_CH < 1) begin : g_err_nch
    $error("sync_debounce_bank: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("sync_debounce_bank: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_err_deb
    $error("sync_debounce_bank: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((CNT_W < 1) || (CNT_W < clog2(DEBOUNCE_CYCLES))) begin : g_err_cnt
    $error("sync_debounce_bank: CNT_W too small for DEBOUNCE_CYCLES");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .INIT_LEVEL      (INIT_LEVEL)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .din   (din[g]),
      .level (level[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_debounce_bank.sv
// ============================================================================
// Module      : tb_sync_debounce_bank
// Description : Directed self-checking bench for sync_debounce_bank
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] din;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  logic [0:0] din_b;
  logic [0:0] level_b;
  logic [0:0] rise_b;
  logic [0:0] fall_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sync_debounce_bank #(
    .N_CH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8), .CNT_W(4), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .din(din),
    .level(level), .rise(rise), .fall(fall)
  );

  // Minimal-latency corner: two sync stages, single-sample debounce, high init.
  sync_debounce_bank #(
    .N_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(1), .INIT_LEVEL(1'b1)
  ) dut_min (
    .clk(clk), .rst(rst), .tick(1'b1), .din(din_b),
    .level(level_b), .rise(rise_b), .fall(fall_b)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic [3:0] din;
    int         n;
    logic [3:0] lv;
    logic [3:0] rs;
    logic [3:0] fl;
  } vec_t;

  vec_t tbl [17];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] lv,
                         input logic [3:0] rs, input logic [3:0] fl);
    chk({nm, ".level"}, level, lv);
    chk({nm, ".rise"},  rise,  rs);
    chk({nm, ".fall"},  fall,  fl);
  endtask

  task automatic do_reset(input logic [3:0] d);
    rst  = 1'b1;
    tick = 1'b1;
    din  = d;
    step(2);
    rst  = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    tick  = 1'b1;
    din   = 4'hF;
    din_b = 1'b1;

    //          rst   tick  din    n   level  rise   fall
    tbl[0]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 10, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF,  1, 4'hF, 4'hF, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 10, 4'hF, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'h0,  1, 4'h0, 4'h0, 4'hF};
    tbl[7]  = '{1'b0, 1'b1, 4'h0,  1, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'h1, 10, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 4'h1,  1, 4'h1, 4'h1, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 4'h1,  1, 4'h1, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 1'b1, 4'h5, 10, 4'h1, 4'h0, 4'h0};
    tbl[12] = '{1'b0, 1'b1, 4'h5,  1, 4'h5, 4'h4, 4'h0};
    tbl[13] = '{1'b0, 1'b1, 4'h5,  1, 4'h5, 4'h0, 4'h0};
    tbl[14] = '{1'b0, 1'b1, 4'hA, 10, 4'h5, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 1'b1, 4'hA,  1, 4'hA, 4'hA, 4'h5};
    tbl[16] = '{1'b0, 1'b1, 4'hA,  1, 4'hA, 4'h0, 4'h0};

    for (int i = 0; i < 17; i++) begin
      rst  = tbl[i].rst;
      tick = tbl[i].tick;
      din  = tbl[i].din;
      step(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].lv, tbl[i].rs, tbl[i].fl);
    end

    // Bounce on channel 1: 1,0,1,0 for 3 clks each, then hold 1.
    do_reset(4'h0);
    chk_all("bounce.rst", 4'h0, 4'h0, 4'h0);
    for (int c = 0; c < 12; c++) begin
      din = ((c / 3) % 2 == 0) ? 4'h2 : 4'h0;
      step(1);
      chk_all($sformatf("bounce.c%0d", c), 4'h0, 4'h0, 4'h0);
    end
    din = 4'h2;
    step(10);
    chk_all("bounce.e10", 4'h0, 4'h0, 4'h0);
    step(1);
    chk_all("bounce.e11", 4'h2, 4'h2, 4'h0);

    // Tick 1 clk in 4: counting ticks land on edges 5,9,...,33.
    do_reset(4'h0);
    for (int c = 0; c < 36; c++) begin
      tick = (c % 4 == 0);
      din  = 4'h4;
      step(1);
      chk_all($sformatf("tick.e%0d", c + 1),
              (c + 1 >= 33) ? 4'h4 : 4'h0,
              (c + 1 == 33) ? 4'h4 : 4'h0, 4'h0);
    end

    // Same, with a one-clk glitch to 0 driven before edge 16: restart, rise at edge 49.
    do_reset(4'h0);
    for (int c = 0; c < 52; c++) begin
      tick = (c % 4 == 0);
      din  = (c == 15) ? 4'h0 : 4'h4;
      step(1);
      chk_all($sformatf("glitch.e%0d", c + 1),
              (c + 1 >= 49) ? 4'h4 : 4'h0,
              (c + 1 == 49) ? 4'h4 : 4'h0, 4'h0);
    end

    // Reset at edge 7 of a channel-3 count; full latency restarts after release.
    do_reset(4'h0);
    din = 4'h8;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk_all($sformatf("midrst.e%0d", e), 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b1;
    step(1);
    chk_all("midrst.e7", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      chk_all($sformatf("midrst.k%0d", k),
              (k == 11) ? 4'h8 : 4'h0, (k == 11) ? 4'h8 : 4'h0, 4'h0);
    end

    // Minimal instance: INIT_LEVEL=1, latency 2+1 edges.
    do_reset(4'h0);
    chk("min.rst.level", {3'b0, level_b}, 4'h1);
    din_b = 1'b0;
    step(2);
    chk("min.e2.level", {3'b0, level_b}, 4'h1);
    step(1);
    chk("min.e3.level", {3'b0, level_b}, 4'h0);
    chk("min.e3.fall",  {3'b0, fall_b},  4'h1);
    chk("min.e3.rise",  {3'b0, rise_b},  4'h0);
    step(1);
    chk("min.e4.fall",  {3'b0, fall_b},  4'h0);
    din_b = 1'b1;
    step(2);
    chk("min.r2.level", {3'b0, level_b}, 4'h0);
    step(1);
    chk("min.r3.level", {3'b0, level_b}, 4'h1);
    chk("min.r3.rise",  {3'b0, rise_b},  4'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
